// File: rtl/spi_status_pkg.sv
// rtl/spi_status_pkg.sv - STATUS bit layout, reset value and sticky-bit mask for spi_status_ctrl
package spi_status_pkg;

    localparam int ST_RX_UNDERFLOW = 0;
    localparam int ST_RX_OVERRUN   = 1;
    localparam int ST_RX_FULL      = 2;
    localparam int ST_TX_COLLISION = 3;
    localparam int ST_TX_EMPTY     = 4;
    localparam int ST_TX_NOT_FULL  = 5;
    localparam int ST_RX_NOT_EMPTY = 6;
    localparam int ST_BUSY         = 7;

    localparam logic [7:0] STATUS_RST  = 8'h30;
    localparam logic [7:0] STICKY_MASK = 8'h0B;

    // Sticky flag update: set wins over a same-cycle clear; clear only touches sticky bits.
    function automatic logic [7:0] sticky_update(
        input logic [7:0] cur,
        input logic [7:0] set,
        input logic       w1c_stb,
        input logic [7:0] w1c_data
    );
        logic [7:0] clr;
        clr = w1c_stb ? (w1c_data & STICKY_MASK) : 8'h00;
        return ((cur & ~clr) | set) & STICKY_MASK;
    endfunction

endpackage

// File: rtl/spi_level_cnt.sv
// rtl/spi_level_cnt.sv - saturating occupancy counter with push/pop acceptance and reject flags
//
// Ports:
//   S_CLK, CLR          clock, asynchronous active-high reset
//   push, pop           requests for this buffer
//   level               registered occupancy, 0..DEPTH
//   full, empty         occupancy after this cycle's update (for the registered STATUS)
//   push_rej, pop_rej   request refused this cycle
module spi_level_cnt #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             S_CLK,
    input  logic             CLR,
    input  logic             push,
    input  logic             pop,
    output logic [CNT_W-1:0] level,
    output logic             full,
    output logic             empty,
    output logic             push_rej,
    output logic             pop_rej
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic             pop_acc;
    logic             push_acc;
    logic [CNT_W-1:0] level_nxt;

    // A pop at zero is refused even with a simultaneous push; a push at full
    // is only taken when a pop frees an entry in the same cycle.
    assign pop_acc  = pop && (level != '0);
    assign push_acc = push && ((level < DEPTH_C) || pop_acc);
    assign push_rej = push && !push_acc;
    assign pop_rej  = pop && !pop_acc;

    always_comb begin
        level_nxt = level;
        if (push_acc && !pop_acc) begin
            level_nxt = level + CNT_W'(1);
        end else if (pop_acc && !push_acc) begin
            level_nxt = level - CNT_W'(1);
        end
    end

    assign full  = (level_nxt == DEPTH_C);
    assign empty = (level_nxt == '0);

    always_ff @(posedge S_CLK or posedge CLR) begin
        if (CLR) begin
            level <= '0;
        end else begin
            level <= level_nxt;
        end
    end

endmodule

// File: rtl/spi_status_ctrl.sv
// rtl/spi_status_ctrl.sv - SPI TX/RX buffer level tracking, sticky error flags, status word and IRQ
//
// Optional feature macro: SPI_STATUS_IRQ_EN (mask register and IRQ logic; IRQ tied 0 otherwise).
//
// Ports:
//   S_CLK, CLR              clock, asynchronous active-high reset
//   TX_PUSH, TX_POP         TX buffer write (host) / read (shifter)
//   RX_PUSH, RX_POP         RX buffer write (shifter) / read (host)
//   SHIFT_BUSY              shifter mid-frame
//   W1C_STB, W1C_DATA       write-1-to-clear of sticky STATUS bits
//   MASK_WE, MASK_DATA      interrupt mask load
//   STATUS                  registered status word
//   TX_LEVEL, RX_LEVEL      buffer occupancy
//   IRQ                     registered interrupt request
module spi_status_ctrl
    import spi_status_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             S_CLK,
    input  logic             CLR,
    input  logic             TX_PUSH,
    input  logic             TX_POP,
    input  logic             RX_PUSH,
    input  logic             RX_POP,
    input  logic             SHIFT_BUSY,
    input  logic             W1C_STB,
    input  logic [7:0]       W1C_DATA,
    input  logic             MASK_WE,
    input  logic [7:0]       MASK_DATA,
    output logic [7:0]       STATUS,
    output logic [CNT_W-1:0] TX_LEVEL,
    output logic [CNT_W-1:0] RX_LEVEL,
    output logic             IRQ
);

    logic tx_full, tx_empty, tx_push_rej, tx_pop_rej_unused;
    logic rx_full, rx_empty, rx_push_rej, rx_pop_rej;

    logic [7:0] sticky_set;
    logic [7:0] status_nxt;

    spi_level_cnt #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_cnt (
        .S_CLK    (S_CLK),
        .CLR      (CLR),
        .push     (TX_PUSH),
        .pop      (TX_POP),
        .level    (TX_LEVEL),
        .full     (tx_full),
        .empty    (tx_empty),
        .push_rej (tx_push_rej),
        .pop_rej  (tx_pop_rej_unused)
    );

    spi_level_cnt #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_cnt (
        .S_CLK    (S_CLK),
        .CLR      (CLR),
        .push     (RX_PUSH),
        .pop      (RX_POP),
        .level    (RX_LEVEL),
        .full     (rx_full),
        .empty    (rx_empty),
        .push_rej (rx_push_rej),
        .pop_rej  (rx_pop_rej)
    );

    always_comb begin
        sticky_set                  = 8'h00;
        sticky_set[ST_RX_UNDERFLOW] = rx_pop_rej;
        sticky_set[ST_RX_OVERRUN]   = rx_push_rej;
        sticky_set[ST_TX_COLLISION] = tx_push_rej;

        status_nxt = sticky_update(STATUS & STICKY_MASK, sticky_set, W1C_STB, W1C_DATA);
        // Level bits come from the post-update counts so they land with the counter itself.
        status_nxt[ST_RX_FULL]      = rx_full;
        status_nxt[ST_TX_EMPTY]     = tx_empty;
        status_nxt[ST_TX_NOT_FULL]  = !tx_full;
        status_nxt[ST_RX_NOT_EMPTY] = !rx_empty;
        status_nxt[ST_BUSY]         = SHIFT_BUSY || !tx_empty;
    end

    always_ff @(posedge S_CLK or posedge CLR) begin
        if (CLR) begin
            STATUS <= STATUS_RST;
        end else begin
            STATUS <= status_nxt;
        end
    end

`ifdef SPI_STATUS_IRQ_EN
    logic [7:0] mask_q;

    always_ff @(posedge S_CLK or posedge CLR) begin
        if (CLR) begin
            mask_q <= 8'h00;
            IRQ    <= 1'b0;
        end else begin
            if (MASK_WE) begin
                mask_q <= MASK_DATA;
            end
            // Built from the registered STATUS, so IRQ trails STATUS by one cycle.
            IRQ <= |(STATUS & mask_q);
        end
    end
`else
    logic mask_unused;
    assign mask_unused = ^{MASK_WE, MASK_DATA};
    assign IRQ         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_status_ctrl.sv
// tb/tb_spi_status_ctrl.sv - directed self-checking bench for spi_status_ctrl at FIFO_DEPTH=4
module tb_spi_status_ctrl;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 3;

    logic             S_CLK;
    logic             CLR;
    logic             TX_PUSH, TX_POP, RX_PUSH, RX_POP;
    logic             SHIFT_BUSY;
    logic             W1C_STB;
    logic [7:0]       W1C_DATA;
    logic             MASK_WE;
    logic [7:0]       MASK_DATA;
    logic [7:0]       STATUS;
    logic [CNT_W-1:0] TX_LEVEL, RX_LEVEL;
    logic             IRQ;

    int checks;
    int failures;

    spi_status_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .S_CLK      (S_CLK),
        .CLR        (CLR),
        .TX_PUSH    (TX_PUSH),
        .TX_POP     (TX_POP),
        .RX_PUSH    (RX_PUSH),
        .RX_POP     (RX_POP),
        .SHIFT_BUSY (SHIFT_BUSY),
        .W1C_STB    (W1C_STB),
        .W1C_DATA   (W1C_DATA),
        .MASK_WE    (MASK_WE),
        .MASK_DATA  (MASK_DATA),
        .STATUS     (STATUS),
        .TX_LEVEL   (TX_LEVEL),
        .RX_LEVEL   (RX_LEVEL),
        .IRQ        (IRQ)
    );

    initial S_CLK = 1'b0;
    always #5 S_CLK = ~S_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge S_CLK);
        #1;
    endtask

    task automatic idle();
        TX_PUSH = 0; TX_POP = 0; RX_PUSH = 0; RX_POP = 0;
        W1C_STB = 0; W1C_DATA = 8'h00; MASK_WE = 0; MASK_DATA = 8'h00;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        CLR = 1;
        SHIFT_BUSY = 0;
        idle();
        #2;
        check("rst_status", STATUS, 8'h30);
        check("rst_tx_level", TX_LEVEL, 0);
        check("rst_rx_level", RX_LEVEL, 0);
        check("rst_irq", IRQ, 0);
        tick();
        tick();
        CLR = 0;

        MASK_WE = 1; MASK_DATA = 8'h02;
        tick(); idle();
        check("mask_write_status", STATUS, 8'h30);

        // TX fill: five pushes into a depth-4 buffer
        TX_PUSH = 1;
        tick();
        check("tx_push1_level", TX_LEVEL, 1);
        check("tx_push1_status", STATUS, 8'hA0);
        tick(); tick(); tick();
        check("tx_push4_level", TX_LEVEL, 4);
        check("tx_push4_status", STATUS, 8'h80);
        tick(); idle();
        check("tx_push5_level", TX_LEVEL, 4);
        check("tx_push5_status", STATUS, 8'h88);

        // Collision re-set on the same cycle as its clear: set wins
        TX_PUSH = 1; W1C_STB = 1; W1C_DATA = 8'h08;
        tick(); idle();
        check("w1c_same_cycle", STATUS, 8'h88);
        W1C_STB = 1; W1C_DATA = 8'hF7;
        tick(); idle();
        check("w1c_nonsticky_ignored", STATUS, 8'h88);
        W1C_STB = 1; W1C_DATA = 8'h08;
        tick(); idle();
        check("w1c_clear", STATUS, 8'h80);

        // TX drain, then a silent pop at zero
        TX_POP = 1;
        tick(); tick(); tick();
        check("tx_pop3_level", TX_LEVEL, 1);
        check("tx_pop3_status", STATUS, 8'hA0);
        tick();
        check("tx_pop4_status", STATUS, 8'h30);
        tick(); idle();
        check("tx_pop_empty_level", TX_LEVEL, 0);
        check("tx_pop_empty_status", STATUS, 8'h30);

        SHIFT_BUSY = 1;
        tick();
        check("busy_shift", STATUS, 8'hB0);
        SHIFT_BUSY = 0;
        tick();
        check("busy_clear", STATUS, 8'h30);

        // RX pop at zero with simultaneous push
        RX_POP = 1; RX_PUSH = 1;
        tick(); idle();
        check("rx_underflow_level", RX_LEVEL, 1);
        check("rx_underflow_status", STATUS, 8'h71);
        W1C_STB = 1; W1C_DATA = 8'h01;
        tick(); idle();
        check("rx_underflow_clear", STATUS, 8'h70);

        RX_PUSH = 1;
        tick(); tick(); tick(); idle();
        check("rx_full_level", RX_LEVEL, 4);
        check("rx_full_status", STATUS, 8'h74);

        RX_PUSH = 1; RX_POP = 1;
        tick(); idle();
        check("rx_full_pushpop_level", RX_LEVEL, 4);
        check("rx_full_pushpop_status", STATUS, 8'h74);

        RX_PUSH = 1;
        tick(); idle();
        check("rx_overrun_level", RX_LEVEL, 4);
        check("rx_overrun_status", STATUS, 8'h76);
        check("irq_lag", IRQ, 0);
        tick();
`ifdef SPI_STATUS_IRQ_EN
        check("irq_set", IRQ, 1);
`else
        check("irq_tied", IRQ, 0);
`endif
        W1C_STB = 1; W1C_DATA = 8'h02;
        tick(); idle();
        check("overrun_clear", STATUS, 8'h74);
`ifdef SPI_STATUS_IRQ_EN
        check("irq_hold", IRQ, 1);
`else
        check("irq_tied2", IRQ, 0);
`endif
        tick();
        check("irq_cleared", IRQ, 0);

        // Reset in the middle of traffic
        TX_PUSH = 1; RX_POP = 1; SHIFT_BUSY = 1;
        tick();
        CLR = 1;
        #1;
        check("clr_status", STATUS, 8'h30);
        check("clr_tx_level", TX_LEVEL, 0);
        check("clr_rx_level", RX_LEVEL, 0);
        check("clr_irq", IRQ, 0);
        tick();
        check("clr_hold_tx_level", TX_LEVEL, 0);
        check("clr_hold_status", STATUS, 8'h30);
        idle(); SHIFT_BUSY = 0;
        CLR = 0;
        RX_PUSH = 1;
        tick(); idle();
        check("post_clr_rx_level", RX_LEVEL, 1);
        check("post_clr_status", STATUS, 8'h70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
